// File: rtl/cii_pkg.sv
// cii_pkg: shared grid geometry, control codes and controller states for the text buffer
package cii_pkg;
    localparam int CHARW = 70;
    localparam int CHARH = 30;
    localparam logic [7:0] BLANK = 8'h20;
    localparam logic [7:0] CR = 8'h0D;
    localparam logic [7:0] LF = 8'h0A;
    localparam logic [7:0] BS = 8'h08;
    typedef enum logic [2:0] {INIT, IDLE, WRITE, NEWLINE, CLEAR, BKSP} state_t;
endpackage

// File: rtl/cii_text_addr_map.sv
// cii_text_addr_map: logical row/column plus scroll offset to linear text RAM address
module cii_text_addr_map import cii_pkg::*; #(
    parameter int AW = 12
) (
    input  logic [4:0]    row,
    input  logic [6:0]    col,
    input  logic [4:0]    top,
    output logic [AW-1:0] addr
);
    logic [5:0] sum;
    logic [4:0] phys;
    // Rows wrap modulo CHARH with one compare-subtract since both operands are < CHARH
    assign sum  = {1'b0, row} + {1'b0, top};
    assign phys = (sum >= 6'(CHARH)) ? 5'(sum - 6'(CHARH)) : sum[4:0];
    assign addr = AW'(phys) * AW'(CHARW) + AW'(col);
endmodule

// File: rtl/cii_text_buffer_ctrl.sv
// cii_text_buffer_ctrl: shares the text RAM between display reads and keyboard-driven writes
module cii_text_buffer_ctrl import cii_pkg::*; #(
    parameter int AW = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          key_valid,
    input  logic [7:0]    key_data,
    output logic          key_ready,
    input  logic          disp_req,
    input  logic [6:0]    disp_char_x,
    input  logic [4:0]    disp_char_y,
    output logic [7:0]    disp_data,
    output logic          disp_data_valid,
    output logic [AW-1:0] ram_addr,
    output logic          ram_we,
    output logic [7:0]    ram_wdata,
    input  logic [7:0]    ram_rdata,
    output logic [6:0]    cursor_x,
    output logic [4:0]    cursor_y,
    output logic [4:0]    top_row,
    output logic          busy
);
    localparam int CELLS = CHARW * CHARH;

    state_t        state;
    logic [AW-1:0] cnt;
    logic [7:0]    data;
    logic          oor_q;
    logic          disp_oor;
    logic          bk_nop;
    logic          wr_req;
    logic [6:0]    bk_x;
    logic [6:0]    wr_x;
    logic [4:0]    bk_y;
    logic [4:0]    wr_y;
    logic [AW-1:0] disp_addr;
    logic [AW-1:0] wr_addr;

    cii_text_addr_map #(.AW(AW)) u_disp_map (
        .row  (disp_char_y),
        .col  (disp_char_x),
        .top  (top_row),
        .addr (disp_addr)
    );

    cii_text_addr_map #(.AW(AW)) u_wr_map (
        .row  (wr_y),
        .col  (wr_x),
        .top  (top_row),
        .addr (wr_addr)
    );

    assign disp_oor  = (disp_char_x >= 7'(CHARW)) || (disp_char_y >= 5'(CHARH));
    assign bk_nop    = (cursor_x == '0) && (cursor_y == '0);
    assign bk_x      = (cursor_x != '0) ? cursor_x - 7'd1 : 7'(CHARW - 1);
    assign bk_y      = (cursor_x != '0) ? cursor_y : cursor_y - 5'd1;
    assign wr_x      = (state == CLEAR) ? cnt[6:0] : (state == BKSP) ? bk_x : cursor_x;
    assign wr_y      = (state == CLEAR) ? 5'(CHARH - 1) : (state == BKSP) ? bk_y : cursor_y;
    // Write enable is masked during reset so the INIT state cannot write before release
    assign wr_req    = rst && ((state == INIT) || (state == WRITE) || (state == CLEAR) ||
                               ((state == BKSP) && !bk_nop));
    assign ram_we    = wr_req && !disp_req;
    assign ram_addr  = disp_req ? (disp_oor ? '0 : disp_addr) : (state == INIT) ? cnt : wr_addr;
    assign ram_wdata = (state == WRITE) ? data : BLANK;
    assign busy      = (state != IDLE);
    assign disp_data = (disp_data_valid && !oor_q) ? ram_rdata : 8'h00;

    // Display read pipeline tracks the RAM's one-cycle read latency
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            disp_data_valid <= 1'b0;
            oor_q           <= 1'b0;
        end else begin
            disp_data_valid <= disp_req;
            oor_q           <= disp_oor;
        end
    end

    // Controller FSM: every RAM-writing state holds still while the display owns the port
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= INIT;
            cnt       <= '0;
            data      <= '0;
            cursor_x  <= '0;
            cursor_y  <= '0;
            top_row   <= '0;
            key_ready <= 1'b0;
        end else begin
            case (state)
                INIT: if (!disp_req) begin
                    if (cnt == AW'(CELLS - 1)) begin
                        cnt       <= '0;
                        state     <= IDLE;
                        key_ready <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                IDLE: if (key_valid && key_ready) begin
                    data <= key_data;
                    if (key_data >= 8'h20 && key_data <= 8'h7E) begin
                        state     <= WRITE;
                        key_ready <= 1'b0;
                    end else if (key_data == CR || key_data == LF) begin
                        state     <= NEWLINE;
                        key_ready <= 1'b0;
                    end else if (key_data == BS) begin
                        state     <= BKSP;
                        key_ready <= 1'b0;
                    end
                end
                WRITE: if (!disp_req) begin
                    if (cursor_x < 7'(CHARW - 1)) begin
                        cursor_x  <= cursor_x + 7'd1;
                        state     <= IDLE;
                        key_ready <= 1'b1;
                    end else begin
                        state <= NEWLINE;
                    end
                end
                NEWLINE: begin
                    cursor_x <= '0;
                    if (cursor_y < 5'(CHARH - 1)) begin
                        cursor_y  <= cursor_y + 5'd1;
                        state     <= IDLE;
                        key_ready <= 1'b1;
                    end else begin
                        top_row <= (top_row == 5'(CHARH - 1)) ? '0 : top_row + 5'd1;
                        cnt     <= '0;
                        state   <= CLEAR;
                    end
                end
                CLEAR: if (!disp_req) begin
                    if (cnt == AW'(CHARW - 1)) begin
                        cnt       <= '0;
                        state     <= IDLE;
                        key_ready <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                BKSP: if (bk_nop) begin
                    state     <= IDLE;
                    key_ready <= 1'b1;
                end else if (!disp_req) begin
                    cursor_x  <= bk_x;
                    cursor_y  <= bk_y;
                    state     <= IDLE;
                    key_ready <= 1'b1;
                end
                default: state <= INIT;
            endcase
        end
    end
endmodule

// File: tb/tb_cii_text_buffer_ctrl.sv
// tb_cii_text_buffer_ctrl: scoreboard bench with a behavioural text RAM and keystroke vector table
module tb_cii_text_buffer_ctrl;
    import cii_pkg::*;
    localparam int AW = 12;

    typedef struct {
        logic [AW-1:0] addr;
        logic [7:0]    data;
    } wr_t;

    typedef struct {
        logic [7:0]    code;
        logic          wr;
        logic [AW-1:0] addr;
        logic [7:0]    data;
        logic [6:0]    x;
        logic [4:0]    y;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          key_valid;
    logic [7:0]    key_data;
    logic          key_ready;
    logic          disp_req;
    logic [6:0]    disp_char_x;
    logic [4:0]    disp_char_y;
    logic [7:0]    disp_data;
    logic          disp_data_valid;
    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [7:0]    ram_wdata;
    logic [7:0]    ram_rdata;
    logic [6:0]    cursor_x;
    logic [4:0]    cursor_y;
    logic [4:0]    top_row;
    logic          busy;

    logic [7:0] mem [0:(1<<AW)-1];
    wr_t        wq[$];
    logic [7:0] dq[$];
    vec_t       tbl[8];
    int         checks = 0;
    int         errors = 0;

    cii_text_buffer_ctrl #(.AW(AW)) dut (
        .clk             (clk),
        .rst             (rst),
        .key_valid       (key_valid),
        .key_data        (key_data),
        .key_ready       (key_ready),
        .disp_req        (disp_req),
        .disp_char_x     (disp_char_x),
        .disp_char_y     (disp_char_y),
        .disp_data       (disp_data),
        .disp_data_valid (disp_data_valid),
        .ram_addr        (ram_addr),
        .ram_we          (ram_we),
        .ram_wdata       (ram_wdata),
        .ram_rdata       (ram_rdata),
        .cursor_x        (cursor_x),
        .cursor_y        (cursor_y),
        .top_row         (top_row),
        .busy            (busy)
    );

    always #10 clk = ~clk;

    // Synchronous single-port RAM with one-cycle read latency
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: every RAM write and every display return is matched against queued expectations
    always @(negedge clk) begin : mon
        wr_t        w;
        logic [7:0] d;
        if (ram_we) begin
            if (wq.size() == 0) begin
                check("unexpected_write_addr", {20'h0, ram_addr}, 32'hFFFFFFFF);
            end else begin
                w = wq.pop_front();
                check("write_addr", {20'h0, ram_addr}, {20'h0, w.addr});
                check("write_data", {24'h0, ram_wdata}, {24'h0, w.data});
            end
        end
        if (disp_data_valid) begin
            if (dq.size() == 0) begin
                check("unexpected_disp_valid", {24'h0, disp_data}, 32'hFFFFFFFF);
            end else begin
                d = dq.pop_front();
                check("disp_data", {24'h0, disp_data}, {24'h0, d});
            end
        end
    end

    task automatic push_wr(input int addr, input logic [7:0] data);
        wr_t w;
        w.addr = AW'(addr);
        w.data = data;
        wq.push_back(w);
    endtask

    task automatic push_init();
        for (int i = 0; i < CHARW * CHARH; i++) push_wr(i, BLANK);
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n = 0;
        while (!(key_ready === 1'b1 && busy === 1'b0) && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(name, {31'h0, key_ready === 1'b1 && busy === 1'b0}, 32'h1);
    endtask

    task automatic wait_top(input logic [4:0] val);
        int n = 0;
        while (top_row !== val && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("wrap_top_row", {27'h0, top_row}, {27'h0, val});
    endtask

    task automatic send_key(input logic [7:0] code);
        key_valid = 1'b1;
        key_data  = code;
        @(posedge clk);
        #1;
        key_valid = 1'b0;
    endtask

    task automatic disp_read(input logic [6:0] x, input logic [4:0] y, input logic [7:0] exp);
        disp_req    = 1'b1;
        disp_char_x = x;
        disp_char_y = y;
        dq.push_back(exp);
        @(posedge clk);
        #1;
        disp_req = 1'b0;
    endtask

    task automatic type_row(input int base, input int clear_base);
        logic [7:0] c;
        for (int i = 0; i < CHARW; i++) begin
            c = 8'h61 + 8'(i % 26);
            push_wr(base + i, c);
            if (i == CHARW - 1) for (int j = 0; j < CHARW; j++) push_wr(clear_base + j, BLANK);
            send_key(c);
            if (i != CHARW - 1) wait_idle(5, "row_char_idle");
        end
    endtask

    initial begin
        tbl[0] = '{8'h41, 1'b1, 12'd0,  8'h41, 7'd1, 5'd0};
        tbl[1] = '{8'h07, 1'b0, 12'd0,  8'h00, 7'd1, 5'd0};
        tbl[2] = '{8'h08, 1'b1, 12'd0,  8'h20, 7'd0, 5'd0};
        tbl[3] = '{8'h08, 1'b0, 12'd0,  8'h00, 7'd0, 5'd0};
        tbl[4] = '{8'h41, 1'b1, 12'd0,  8'h41, 7'd1, 5'd0};
        tbl[5] = '{8'h0D, 1'b0, 12'd0,  8'h00, 7'd0, 5'd1};
        tbl[6] = '{8'h5A, 1'b1, 12'd70, 8'h5A, 7'd1, 5'd1};
        tbl[7] = '{8'h0A, 1'b0, 12'd0,  8'h00, 7'd0, 5'd2};
        key_valid   = 1'b0;
        key_data    = 8'h00;
        disp_req    = 1'b0;
        disp_char_x = '0;
        disp_char_y = '0;
        rst         = 1'b1;
        #1 rst = 1'b0;
        #4;
        check("rst_key_ready", {31'h0, key_ready}, 32'h0);
        check("rst_ram_we", {31'h0, ram_we}, 32'h0);
        check("rst_disp_valid", {31'h0, disp_data_valid}, 32'h0);
        check("rst_disp_data", {24'h0, disp_data}, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h1);
        check("rst_cursor", {20'h0, cursor_x, cursor_y}, 32'h0);
        check("rst_top_row", {27'h0, top_row}, 32'h0);
        @(posedge clk);
        #1;
        push_init();
        rst = 1'b1;
        wait_idle(2200, "init_done");
        check("init_all_writes", wq.size(), 32'h0);

        for (int i = 0; i < 8; i++) begin
            if (tbl[i].wr) push_wr(int'(tbl[i].addr), tbl[i].data);
            send_key(tbl[i].code);
            wait_idle(5, "vec_idle");
            check("vec_cursor_x", {25'h0, cursor_x}, {25'h0, tbl[i].x});
            check("vec_cursor_y", {27'h0, cursor_y}, {27'h0, tbl[i].y});
            check("vec_writes_done", wq.size(), 32'h0);
        end

        disp_read(7'd0,  5'd0,  8'h41);
        disp_read(7'd0,  5'd1,  8'h5A);
        disp_read(7'd70, 5'd0,  8'h00);
        disp_read(7'd0,  5'd30, 8'h00);
        disp_read(7'd69, 5'd29, 8'h20);
        @(posedge clk);
        #1;
        check("disp_reads_done", dq.size(), 32'h0);

        for (int i = 0; i < 3; i++) begin
            send_key(LF);
            wait_idle(5, "lf_idle");
        end
        check("at_row5", {20'h0, cursor_x, cursor_y}, {20'h0, 7'd0, 5'd5});
        push_wr(4 * CHARW + CHARW - 1, BLANK);
        send_key(BS);
        wait_idle(5, "bksp_idle");
        check("bksp_wrap", {20'h0, cursor_x, cursor_y}, {20'h0, 7'd69, 5'd4});
        check("bksp_write", wq.size(), 32'h0);
        for (int i = 0; i < 25; i++) begin
            send_key(LF);
            wait_idle(5, "lf_idle");
        end
        check("at_row29", {20'h0, cursor_x, cursor_y}, {20'h0, 7'd0, 5'd29});

        type_row(29 * CHARW, 0);
        wait_top(5'd1);
        repeat (5) @(posedge clk);
        #1;
        check("clear_before_stall", wq.size(), 32'd65);
        disp_req    = 1'b1;
        disp_char_x = 7'd0;
        disp_char_y = 5'd29;
        for (int i = 0; i < 10; i++) begin
            dq.push_back(BLANK);
            @(negedge clk);
            check("stall_ram_we", {31'h0, ram_we}, 32'h0);
            @(posedge clk);
            #1;
        end
        disp_req = 1'b0;
        check("clear_frozen", wq.size(), 32'd65);
        wait_idle(100, "clear_idle");
        check("clear_all_writes", wq.size(), 32'h0);
        check("wrap_cursor", {20'h0, cursor_x, cursor_y}, {20'h0, 7'd0, 5'd29});
        check("wrap_top", {27'h0, top_row}, 32'h1);
        disp_read(7'd5, 5'd28, 8'h66);
        disp_read(7'd0, 5'd0,  8'h5A);
        disp_read(7'd3, 5'd29, 8'h20);
        @(posedge clk);
        #1;
        check("wrap_reads_done", dq.size(), 32'h0);

        type_row(0, CHARW);
        wait_top(5'd2);
        repeat (30) @(posedge clk);
        #1;
        check("clear_at_30", wq.size(), 32'd40);
        rst = 1'b0;
        #1;
        check("mid_rst_key_ready", {31'h0, key_ready}, 32'h0);
        check("mid_rst_ram_we", {31'h0, ram_we}, 32'h0);
        check("mid_rst_busy", {31'h0, busy}, 32'h1);
        check("mid_rst_top_row", {27'h0, top_row}, 32'h0);
        check("mid_rst_cursor", {20'h0, cursor_x, cursor_y}, 32'h0);
        check("mid_rst_disp_valid", {31'h0, disp_data_valid}, 32'h0);
        wq.delete();
        push_init();
        @(posedge clk);
        #1;
        rst = 1'b1;
        wait_idle(2200, "reinit_done");
        check("reinit_all_writes", wq.size(), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
